// File: rtl/sprite_scroll_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_scroll_ctrl_if
// Brief    : Frame-control and render-output bundle for sprite_scroll_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_scroll_ctrl_if;
  logic        i_frame_tick;
  logic        i_btn_left;
  logic        i_btn_right;
  logic        i_pause;
  logic        i_sprite_vis;
  logic        i_obstacle_vis;
  logic [9:0]  o_sprite_x;
  logic [9:0]  o_sprite_y;
  logic [31:0] o_curr_y;
  logic        o_hit;
  logic        o_game_over;
  logic        o_busy;

  modport slave (
    input  i_frame_tick, i_btn_left, i_btn_right, i_pause, i_sprite_vis, i_obstacle_vis,
    output o_sprite_x, o_sprite_y, o_curr_y, o_hit, o_game_over, o_busy
  );

  modport master (
    output i_frame_tick, i_btn_left, i_btn_right, i_pause, i_sprite_vis, i_obstacle_vis,
    input  o_sprite_x, o_sprite_y, o_curr_y, o_hit, o_game_over, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/sprite_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sprite_scroll_ctrl
// Brief    : Per-frame player motion, background scroll and collision freeze.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_scroll_ctrl #(
  parameter logic [9:0]  BASE_XPOS   = 10'd315,
  parameter logic [9:0]  BASE_YPOS   = 10'd240,
  parameter logic [9:0]  X_MIN       = 10'd0,
  parameter logic [9:0]  X_MAX       = 10'd624,
  parameter logic [9:0]  STEP        = 10'd2,
  parameter logic [31:0] SCROLL_STEP = 32'd1,
  parameter logic [31:0] SCROLL_WRAP = 32'd480
) (
  input  wire logic          clk,
  input  wire logic          reset,
  sprite_scroll_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_MOVE    = 3'd2,
    S_SCROLL  = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_left_s1, r_left_s2, r_right_s1, r_right_s2;
  logic        r_btn_l, r_btn_r;
  logic        r_coll_latch, r_coll_shadow;
  logic [9:0]  r_next_x, r_sprite_x;
  logic [31:0] r_next_y, r_curr_y;
  logic        r_hit, r_game_over;

  logic        w_coll;
  logic [10:0] w_left_lim, w_right_sum;
  logic [32:0] w_scroll_sum;
  logic [9:0]  w_move_x;
  logic [31:0] w_scroll_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left_s1  <= 1'b0;
      r_left_s2  <= 1'b0;
      r_right_s1 <= 1'b0;
      r_right_s2 <= 1'b0;
    end else begin
      r_left_s1  <= bus.i_btn_left;
      r_left_s2  <= r_left_s1;
      r_right_s1 <= bus.i_btn_right;
      r_right_s2 <= r_right_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.i_frame_tick && !r_game_over && !bus.i_pause) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_MOVE;
      S_MOVE:    w_state_nxt = S_SCROLL;
      S_SCROLL:  w_state_nxt = S_COMMIT;
      S_COMMIT:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Sums are one bit wider so the clamps never see a wrapped value.
  always_comb begin
    w_left_lim   = {1'b0, X_MIN} + {1'b0, STEP};
    w_right_sum  = {1'b0, r_sprite_x} + {1'b0, STEP};
    w_scroll_sum = {1'b0, r_curr_y} + {1'b0, SCROLL_STEP};
    w_move_x     = r_sprite_x;
    if (r_btn_l && !r_btn_r)
      w_move_x = ({1'b0, r_sprite_x} < w_left_lim) ? X_MIN : (r_sprite_x - STEP);
    else if (r_btn_r && !r_btn_l)
      w_move_x = (w_right_sum > {1'b0, X_MAX}) ? X_MAX : w_right_sum[9:0];
    w_scroll_y = (w_scroll_sum >= {1'b0, SCROLL_WRAP}) ? 32'd0 : w_scroll_sum[31:0];
  end

  assign w_coll = bus.i_sprite_vis & bus.i_obstacle_vis & ~r_game_over;

  // A hit in the CAPTURE cycle re-arms the latch for the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_coll_latch <= 1'b0;
    else if (r_game_over || (r_state == S_COMMIT && r_coll_shadow))
      r_coll_latch <= 1'b0;
    else if (w_coll)
      r_coll_latch <= 1'b1;
    else if (r_state == S_CAPTURE)
      r_coll_latch <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_l       <= 1'b0;
      r_btn_r       <= 1'b0;
      r_coll_shadow <= 1'b0;
      r_next_x      <= BASE_XPOS;
      r_next_y      <= 32'd0;
      r_sprite_x    <= BASE_XPOS;
      r_curr_y      <= 32'd0;
      r_hit         <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        S_CAPTURE: begin
          r_btn_l       <= r_left_s2;
          r_btn_r       <= r_right_s2;
          r_coll_shadow <= r_coll_latch;
        end
        S_MOVE:   r_next_x <= w_move_x;
        S_SCROLL: r_next_y <= w_scroll_y;
        S_COMMIT: begin
          r_sprite_x <= r_next_x;
          r_curr_y   <= r_next_y;
          if (r_coll_shadow) begin
            r_hit       <= 1'b1;
            r_game_over <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_sprite_x  = r_sprite_x;
  assign bus.o_sprite_y  = BASE_YPOS;
  assign bus.o_curr_y    = r_curr_y;
  assign bus.o_hit       = r_hit;
  assign bus.o_game_over = r_game_over;
  assign bus.o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
